pipe_muldiv: RTL



---
 rtl/pipe_muldiv_if.sv | 29 ++
 rtl/pipe_muldiv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_muldiv_if.sv
// Operand, strobe and result bundle between decode and the pipe_muldiv execute unit.
// The decode side drives through master; pipe_muldiv connects as slave.
interface pipe_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mult;
  logic             multu;
  logic             div;
  logic             divu;
  logic             mthi;
  logic             mtlo;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output a, b, mult, multu, div, divu, mthi, mtlo, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  a, b, mult, multu, div, divu, mthi, mtlo, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/pipe_muldiv.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers.
// Define PIPE_MULDIV_FAST_MULT_EN to make mult/multu single-cycle; divides stay iterative.
module pipe_muldiv #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  pipe_muldiv_if.slave bus
);
  // state  | meaning
  // S_IDLE | HI/LO stable, accepts starts and mthi/mtlo
  // S_CALC | one multiply or divide iteration per edge, counter WIDTH-1 down to 0
  // S_FIX  | apply signs, write HI/LO, pulse done
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W2-1:0]   r_acc;
  logic [WIDTH-1:0] r_opd;
  logic            r_is_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic            r_done;

  logic            w_idle;
  logic            w_any_start;
  logic            w_accept;
  logic            w_sel_div;
  logic            w_sel_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic            w_mt_ok;
  logic            w_fast_go;
  logic            w_iter_go;
  logic [W2-1:0]   w_fast_prod;

  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_mul_nxt;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_sub;
  logic [W2-1:0]    w_div_nxt;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_idle       = (r_state == S_IDLE);
  assign w_any_start  = bus.div | bus.divu | bus.mult | bus.multu;
  assign w_accept     = w_idle & ~bus.flush & w_any_start;
  assign w_mt_ok      = w_idle & ~bus.flush & ~w_any_start;
  assign w_sel_div    = bus.div | bus.divu;
  assign w_sel_signed = bus.div | (~bus.divu & bus.mult);
  assign w_a_neg      = w_sel_signed & bus.a[WIDTH-1];
  assign w_b_neg      = w_sel_signed & bus.b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag      = w_b_neg ? -bus.b : bus.b;

`ifdef PIPE_MULDIV_FAST_MULT_EN
  logic [W2-1:0] w_fast_mag;
  assign w_fast_mag  = W2'(w_a_mag) * W2'(w_b_mag);
  assign w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
  assign w_fast_go   = w_accept & ~w_sel_div;
`else
  assign w_fast_prod = '0;
  assign w_fast_go   = 1'b0;
`endif
  assign w_iter_go = w_accept & ~w_fast_go;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits still to shift in / quotient bits}.
  assign w_div_sh  = r_acc[W2-1:WIDTH-1];
  assign w_div_ok  = (w_div_sh >= {1'b0, r_opd});
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_opd;
  assign w_div_nxt = {(w_div_ok ? w_div_sub : w_div_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ok};

  always_comb begin
    w_res_hi = r_acc[W2-1:WIDTH];
    w_res_lo = r_acc[WIDTH-1:0];
    if (r_is_div) begin
      w_res_lo = r_dz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
      w_res_hi = r_neg_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
    end else begin
      {w_res_hi, w_res_lo} = r_neg_q ? -r_acc : r_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_iter_go) w_state_nxt = S_CALC;
      S_CALC: begin
        if (bus.flush)          w_state_nxt = S_IDLE;
        else if (r_cnt == '0)   w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_iter_go) begin
            r_cnt    <= CW'(WIDTH - 1);
            r_is_div <= w_sel_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= w_sel_div & (bus.b == '0);
            r_opd    <= w_sel_div ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (w_sel_div ? w_a_mag : w_b_mag)};
          end else if (w_fast_go) begin
            {r_hi, r_lo} <= w_fast_prod;
            r_done       <= 1'b1;
          end else if (w_mt_ok) begin
            if (bus.mthi) r_hi <= bus.a;
            if (bus.mtlo) r_lo <= bus.a;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_cnt <= '0;
          end else begin
            r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = ~w_idle;
  assign bus.done = r_done;
endmodule
